memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//   Data-memory access stage of the 5-stage pipeline, directly downstream of the EX/MEM latch.
//   - Consumes the latched ALU result, store data and instruction from that latch.
//   - Runs the load/store handshake with a variable-latency data memory.
//   - Back-pressures the pipeline while an access is outstanding.
//   - Registers the writeback bundle (MEM/WB) for the register file.
// PARAMETERS
//   ADDR_W          12   data-memory word address width; taken from alu_output[ADDR_W-1:0]
//   TIMEOUT_CYCLES  64   max cycles in WAIT before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//   clock          in   1   single clock; all state updates on rising edge
//   reset          in   1   asynchronous, active-low; clears all state immediately
//   alu_output     in   32  EX/MEM ALU result (load/store address or writeback value)
//   alu_in_B_output in  32  EX/MEM store data
//   instruction_output in 32 EX/MEM instruction word
//   in_valid       in   1   EX/MEM slot holds a real instruction (0 = bubble)
//   dmem_addr      out  ADDR_W  data-memory address
//   dmem_wdata     out  32  store data
//   dmem_req       out  1   access request, held until dmem_ack
//   dmem_we        out  1   1 = store, 0 = load; qualified by dmem_req
//   dmem_rdata     in   32  load data, valid in the dmem_ack cycle
//   dmem_ack       in   1   access complete; sampled only while dmem_req=1
//   stall_out      out  1   freeze PC, F/D, D/X and EX/MEM latches this cycle
//   wb_data        out  32  value to write to the register file
//   wb_rd          out  5   destination register
//   wb_we          out  1   register-file write enable
//   wb_valid       out  1   MEM/WB slot holds a retired instruction
//   wb_instruction out  32  instruction word forwarded to writeback/bypass logic
//   mem_err        out  1   sticky access-timeout flag
// BEHAVIOUR
//   Decode: opcode = instr[31:27], rd = instr[26:22].
//     - sw = 5'b00111, lw = 5'b01000.
//     - is_mem = in_valid & (lw | sw).
//   FSM states: IDLE, WAIT.
//   IDLE:
//     - dmem_req = is_mem, combinational.
//     - addr, wdata and we come straight from the inputs.
//     - ack in the same cycle = zero-wait access; stay in IDLE.
//     - req without ack: capture addr/wdata/we/instr into holding registers, go to WAIT.
//   WAIT:
//     - dmem_req=1 and memory outputs are driven from the holding registers (independent of upstream).
//     - dmem_ack -> IDLE.
//   stall_out = dmem_req & ~dmem_ack.
//     - Non-memory ops never stall.
//     - dmem_ack while dmem_req=0 is ignored.
//   MEM/WB output register loads every cycle the stage completes an instruction (1-cycle latency):
//     - Non-memory op: wb_data = alu_output, wb_we = 1.
//     - Load: wb_data = dmem_rdata captured on the ack edge, wb_we = 1.
//     - Store: wb_we = 0.
//     - Bubble (in_valid=0), or cycle with stall_out=1: wb_valid=0, wb_we=0 (bubble inserted).
//     - rd = 0: wb_we forced 0.
//   Reset values: state=IDLE; wb_*=0; dmem_req=0; stall_out=0; mem_err=0.
//     - Reset mid-WAIT drops dmem_req asynchronously; the access is abandoned and no writeback occurs.
// CONFIGURATION
//   MEM_TIMEOUT_EN defined:
//     - Counter increments each WAIT cycle and clears on entering WAIT.
//     - After TIMEOUT_CYCLES cycles without ack: drop dmem_req, go to IDLE, deassert stall_out.
//     - Retire the instruction with wb_valid=1, wb_we=0; set mem_err=1 until reset.
//   MEM_TIMEOUT_EN not defined: no counter, WAIT waits indefinitely, mem_err tied 0.
// STRUCTURE
//   Package proc_pkg: opcode constants (OP_SW, OP_LW), field slice positions, FSM state encoding.
//   Sub-module mem_access_fsm: state, holding registers, req/stall generation, timeout counter.
//   Top level: decode plus the MEM/WB output register.
// TESTING
//   1. add r3 result 0x0000_1234, in_valid=1 -> next cycle wb_data=0x1234, wb_rd=3, wb_we=1, stall_out never 1.
//   2. lw r5, ack same cycle, rdata 0xDEAD_BEEF -> no stall; next cycle wb_data=0xDEADBEEF, wb_rd=5, wb_we=1.
//   3. sw to addr 0x010, data 0xA5A5_A5A5, ack after 3 cycles:
//      - stall_out=1 for exactly 3 cycles; dmem_addr/wdata stable while upstream inputs change.
//      - then wb_valid=1, wb_we=0.
//   4. lw r0 and a bubble (in_valid=0) -> wb_we=0 on both; stray dmem_ack while idle has no effect.
//   5. reset asserted in the 2nd WAIT cycle -> dmem_req and stall_out fall immediately;
//      wb_valid stays 0 after release.
//   6. With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives:
//      - stall_out drops after 4 WAIT cycles; mem_err=1 and stays 1; wb_we=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the pipeline memory stage: opcode encodings,
// instruction field positions, access FSM states and the MEM/WB bundle.
package proc_pkg;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RD_MSB     = 26;
  localparam int unsigned RD_LSB     = 22;

  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] instr;
  } wb_bundle_t;

  function automatic logic [4:0] instr_opcode(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Load/store handshake with a variable-latency data memory: IDLE/WAIT FSM,
// holding registers and stall generation. MEM_TIMEOUT_EN adds an abort counter.
module mem_access_fsm
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              is_mem,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  input  logic [31:0]       instr_in,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              stall,
  output logic              busy,
  output logic              in_wait,
  output logic              wait_done,
  output logic              timeout_hit,
  output logic [31:0]       held_instr,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]       hold_wdata_q, hold_wdata_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic              hold_we_q, hold_we_d;
  logic              req_raw;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_instr_d = hold_instr_q;
    hold_we_d    = hold_we_q;
    req_raw      = 1'b0;
    dmem_addr    = addr_in;
    dmem_wdata   = wdata_in;
    dmem_we      = is_store;
    wait_done    = 1'b0;
    timeout_hit  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        req_raw = is_mem;
        if (is_mem && !dmem_ack) begin
          state_d      = ST_WAIT;
          hold_addr_d  = addr_in;
          hold_wdata_d = wdata_in;
          hold_instr_d = instr_in;
          hold_we_d    = is_store;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        // Upstream may change freely here; the memory sees only the captured access.
        dmem_addr  = hold_addr_q;
        dmem_wdata = hold_wdata_q;
        dmem_we    = hold_we_q;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_hit = 1'b1;
          mem_err_d   = 1'b1;
          state_d     = ST_IDLE;
        end else
`endif
        begin
          req_raw = 1'b1;
          if (dmem_ack) begin
            wait_done = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates the request directly so an in-flight access is dropped at once,
  // even while the upstream latch still presents a memory op.
  assign dmem_req   = req_raw & reset;
  assign stall      = dmem_req & ~dmem_ack;
  assign busy       = req_raw & ~dmem_ack;
  assign in_wait    = (state_q == ST_WAIT);
  assign held_instr = hold_instr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      // NOTE: holding registers are cleared too, so an abandoned access leaves nothing stale.
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_instr_q <= '0;
      hold_we_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop sample pre-edge values, independent of order.
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_instr_q <= hold_instr_d;
      hold_we_q    <= hold_we_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: rtl/memory_stage.sv
// Data-memory access stage: decodes the EX/MEM slot, drives the memory handshake
// and registers the MEM/WB bundle. Optional access timeout via MEM_TIMEOUT_EN.
module memory_stage
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       alu_output,
  input  logic [31:0]       alu_in_B_output,
  input  logic [31:0]       instruction_output,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_out,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              wb_valid,
  output logic [31:0]       wb_instruction,
  output logic              mem_err
);

  logic [4:0]  in_opcode;
  logic        is_lw, is_sw, is_mem;
  logic        busy, in_wait, wait_done, timeout_hit;
  logic [31:0] held_instr;

  logic [31:0] src_instr;
  logic [4:0]  src_opcode, src_rd;
  logic        src_valid;
  wb_bundle_t  wb_d, wb_q;

  always_comb begin
    in_opcode = instr_opcode(instruction_output);
    is_lw     = in_valid & (in_opcode == OP_LW);
    is_sw     = in_valid & (in_opcode == OP_SW);
    is_mem    = is_lw | is_sw;
  end

  mem_access_fsm #(
    .ADDR_W(ADDR_W)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_access (
    .clock      (clock),
    .reset      (reset),
    .is_mem     (is_mem),
    .is_store   (is_sw),
    .addr_in    (alu_output[ADDR_W-1:0]),
    .wdata_in   (alu_in_B_output),
    .instr_in   (instruction_output),
    .dmem_ack   (dmem_ack),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .stall      (stall_out),
    .busy       (busy),
    .in_wait    (in_wait),
    .wait_done  (wait_done),
    .timeout_hit(timeout_hit),
    .held_instr (held_instr),
    .mem_err    (mem_err)
  );

  // A WAIT completion retires the captured instruction, not whatever sits upstream.
  always_comb begin
    if (in_wait) begin
      src_instr = held_instr;
      src_valid = wait_done | timeout_hit;
    end else begin
      src_instr = instruction_output;
      src_valid = in_valid & ~busy;
    end
    src_opcode = instr_opcode(src_instr);
    src_rd     = instr_rd(src_instr);

    wb_d = '0;
    if (src_valid) begin
      wb_d.valid = 1'b1;
      wb_d.rd    = src_rd;
      wb_d.instr = src_instr;
      wb_d.data  = (src_opcode == OP_LW) ? dmem_rdata : alu_output;
      wb_d.we    = (src_opcode != OP_SW) & ~timeout_hit & (src_rd != 5'd0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_valid       = wb_q.valid;
  assign wb_we          = wb_q.we;
  assign wb_rd          = wb_q.rd;
  assign wb_data        = wb_q.data;
  assign wb_instruction = wb_q.instr;

endmodule
